stream_mux: RTL and testbench
=============================

STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter WIDTH, default 16, data bits per channel.
REQ-002 Parameter CHANNELS, default 16, number of input channels; legal range 2..16.
REQ-003 Derived parameter SEL_W = clog2(CHANNELS), width of the channel index.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  in  CHANNELS  per-channel data-valid.
REQ-008 in_ready  out  CHANNELS  per-channel accept; combinational.
REQ-009 mode  in  1  selection mode: 0 = explicit select, 1 = round-robin.
REQ-010 sel  in  SEL_W  channel index used when mode=0.
REQ-011 out_data  out  WIDTH  registered output word.
REQ-012 out_chan  out  SEL_W  registered index of the channel that supplied out_data.
REQ-013 out_valid  out  1  output register holds an unconsumed word.
REQ-014 out_ready  in  1  downstream accept.

Function
REQ-015 Single output register stage; a transfer out occurs in a cycle with out_valid=1 and out_ready=1.
REQ-016 load_en = !out_valid || out_ready (combinational); the register accepts a new word only when load_en=1.
REQ-017 Mode 0: grant = sel when in_valid[sel]=1; otherwise no grant, even if other channels are valid.
REQ-018 Mode 0: sel >= CHANNELS produces no grant.
REQ-019 Mode 1: grant = first channel with in_valid=1, searching ptr+1, ptr+2, ... modulo CHANNELS, ending at ptr itself; no grant when all in_valid=0.
REQ-020 in_ready[i] = 1 only for i = grant and only when load_en=1; all other bits 0.
REQ-021 Input transfer on channel i when in_valid[i] && in_ready[i]; at that edge out_data <= that channel's word, out_chan <= i, out_valid <= 1.
REQ-022 When load_en=1 and there is no grant, out_valid <= 0; out_data and out_chan hold.
REQ-023 When load_en=0, out_data, out_chan and out_valid hold.
REQ-024 Simultaneous output drain and input grant in one cycle: both transfers complete; sustained throughput is one word per cycle.
REQ-025 Latency: one cycle from input transfer to out_valid=1 with that word.
REQ-026 Round-robin pointer ptr (SEL_W bits) <= granted channel on each mode-1 input transfer; ptr holds on mode-0 transfers and on idle cycles.
REQ-027 Pointer wrap: the search index is computed modulo CHANNELS, so ptr=CHANNELS-1 searches from channel 0.
REQ-028 A mode change takes effect combinationally in the same cycle; a word already in the output register is unaffected.
REQ-029 in_ready has no combinational dependence on in_valid of non-granted channels beyond the grant computation; there is no path from in_ready to in_valid.

Reset
REQ-030 While rst=1 at a rising edge: out_valid <= 0, out_data <= 0, out_chan <= 0, ptr <= CHANNELS-1.
REQ-031 While rst=1, in_ready = all zeros regardless of other inputs.
REQ-032 Reset asserted mid-operation discards any pending output word; no input transfer occurs in a reset cycle.
REQ-033 After reset, the first mode-1 grant goes to the lowest-numbered valid channel.

Verification (WIDTH=16, CHANNELS=4)
REQ-034 Reset, then mode=0, sel=2, in_valid=0100, ch2 data=16'hBEEF, out_ready=1 -> next cycle out_valid=1, out_data=16'hBEEF, out_chan=2.
REQ-035 Mode=0, sel=1, in_valid=1101 -> in_ready=0000 and out_valid falls to 0 after the current word drains.
REQ-036 Mode=1 from reset, in_valid=1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0, one word per cycle.
REQ-037 Mode=1, out_valid=1, out_ready=0 for 3 cycles -> in_ready=0000 and out_data, out_chan stable for those cycles; with out_ready=1 the next grant completes in the same cycle as the drain.
REQ-038 rst=1 asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, in_ready=0000; after release, the first mode-1 grant goes to channel 0.
REQ-039 Mode=1 with ptr=1, in_valid=0011 -> grant channel 0 (wrap-around), then channel 1.

Source files
------------

// File: rtl/stream_mux.sv
// Purpose : N-to-1 stream multiplexer, explicit-select or round-robin arbitration, one output register.
// Latency : one cycle from input handshake to out_valid with that word; one word per cycle sustained.
// Backpress: in_ready only to the granted channel, and only when the output register is empty or draining.
module stream_mux #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Output register and round-robin pointer.
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_chan_q,  out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    // Arbitration result.
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             load_en;
    logic             in_xfer;
    int               cand;

    // The register may take a new word when it is empty or being drained this cycle.
    assign load_en = !out_valid_q || out_ready;

    // Grant: explicit select honours only the selected channel (an out-of-range
    // select matches no channel); round-robin searches ptr+1 .. ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        if (!mode) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                cand = int'(ptr_q) + k;
                if (cand >= CHANNELS) begin
                    cand = cand - CHANNELS;
                end
                if (!grant_vld && in_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(cand);
                end
            end
        end
    end

    // Ready goes only to the winner; nothing is accepted during reset.
    always_comb begin
        in_ready = '0;
        if (!rst && load_en && grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign in_xfer = !rst && load_en && grant_vld;

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (in_xfer) begin
            out_data_d  = in_data[grant_idx*WIDTH +: WIDTH];
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                ptr_d = grant_idx;
            end
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any pending word and parks the pointer so
    // the first round-robin search starts at channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SEL_W'(CHANNELS - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux (WIDTH=16, CHANNELS=4): directed scenarios plus random traffic,
// scoreboarded against a transaction-level reference model.
// Expected words are queued at input handshake and popped by an independent output monitor.
module tb_stream_mux;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH*W-1:0]  in_data;
    logic [CH-1:0]    in_valid;
    logic [CH-1:0]    in_ready;
    logic             mode;
    logic [SW-1:0]    sel;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_chan;
    logic             out_valid;
    logic             out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit               m_valid = 1'b0;
    int               m_ptr   = CH - 1;
    logic [W+SW-1:0]  exp_q[$];
    bit               mon_en  = 1'b0;

    stream_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .sel      (sel),
        .out_data (out_data),
        .out_chan (out_chan),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: apply inputs, predict and check in_ready, then advance the model.
    task automatic cycle(input logic r, input logic m, input logic [SW-1:0] s,
                         input logic [CH-1:0] v, input logic [CH*W-1:0] d, input logic ordy);
        bit            gv;
        int            g;
        bit            ld;
        logic [CH-1:0] er;
        rst = r; mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
        gv = 1'b0;
        g  = 0;
        if (!m) begin
            if (int'(s) < CH && v[s]) begin
                gv = 1'b1;
                g  = int'(s);
            end
        end else begin
            for (int k = 1; k <= CH; k++) begin
                int c;
                c = (m_ptr + k) % CH;
                if (!gv && v[c]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end
        ld = !m_valid || ordy;
        er = '0;
        if (!r && gv && ld) er[g] = 1'b1;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(er));
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            m_ptr   = CH - 1;
            exp_q.delete();
        end else if (ld) begin
            if (gv) begin
                exp_q.push_back({d[g*W +: W], SW'(g)});
                m_valid = 1'b1;
                if (m) m_ptr = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    function automatic logic [CH*W-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    // Output monitor: occupancy, hold stability while stalled, and in-order delivery.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_word: got %0h/%0d with no word expected", out_data, out_chan);
                end else if (out_ready === 1'b1) begin
                    logic [W+SW-1:0] e;
                    e = exp_q.pop_front();
                    check("out_word", 32'({out_data, out_chan}), 32'(e));
                end else begin
                    check("hold_word", 32'({out_data, out_chan}), 32'(exp_q[0]));
                end
            end
        end
    end

    initial begin
        logic [CH*W-1:0] d;
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset with inputs asserted: no ready, cleared register.
        cycle(1'b1, 1'b1, 2'd0, 4'b1111, rnd_data(), 1'b1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_chan",  32'(out_chan),  32'd0);

        // Explicit select of channel 2.
        d = rnd_data();
        d[2*W +: W] = 16'hBEEF;
        cycle(1'b0, 1'b0, 2'd2, 4'b0100, d, 1'b1);
        check("sel2_valid", 32'(out_valid), 32'd1);
        check("sel2_data",  32'(out_data),  32'hBEEF);
        check("sel2_chan",  32'(out_chan),  32'd2);

        // Selected channel idle: no grant although others are valid; register empties.
        cycle(1'b0, 1'b0, 2'd1, 4'b1101, rnd_data(), 1'b1);
        cycle(1'b0, 1'b0, 2'd1, 4'b1101, rnd_data(), 1'b1);
        check("sel_idle_valid", 32'(out_valid), 32'd0);

        // Round-robin from reset with all channels valid: 0,1,2,3,0.
        cycle(1'b1, 1'b0, 2'd0, 4'b0000, rnd_data(), 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 2'd0, 4'b1111, rnd_data(), 1'b1);
            check("rr_seq", 32'(out_chan), 32'(i % CH));
        end

        // Stall three cycles, then drain and reload in the same cycle.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 2'd0, 4'b1111, rnd_data(), 1'b0);
            check("stall_chan", 32'(out_chan), 32'd0);
        end
        cycle(1'b0, 1'b1, 2'd0, 4'b1111, rnd_data(), 1'b1);
        check("drain_reload_chan", 32'(out_chan), 32'd1);

        // Reset while a word is stalled, then first round-robin grant is channel 0.
        cycle(1'b0, 1'b1, 2'd0, 4'b0000, rnd_data(), 1'b0);
        cycle(1'b1, 1'b1, 2'd0, 4'b1111, rnd_data(), 1'b0);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_data",  32'(out_data),  32'd0);
        cycle(1'b0, 1'b1, 2'd0, 4'b1111, rnd_data(), 1'b1);
        check("post_rst_chan", 32'(out_chan), 32'd0);

        // Pointer at 1, channels 0 and 1 valid: wrap to 0, then 1.
        cycle(1'b1, 1'b0, 2'd0, 4'b0000, rnd_data(), 1'b1);
        cycle(1'b0, 1'b1, 2'd0, 4'b0010, rnd_data(), 1'b1);
        check("wrap_setup", 32'(out_chan), 32'd1);
        cycle(1'b0, 1'b1, 2'd0, 4'b0011, rnd_data(), 1'b1);
        check("wrap_first", 32'(out_chan), 32'd0);
        cycle(1'b0, 1'b1, 2'd0, 4'b0011, rnd_data(), 1'b1);
        check("wrap_second", 32'(out_chan), 32'd1);

        // Random traffic, occasional reset and mode flips.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 60) == 0), 1'($urandom), 2'($urandom),
                  4'($urandom), rnd_data(), ($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
